// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI definitions.
//   - channel-voice status-nibble constants
//   - receiver state enum used by the byte receiver FSM
//   - exp_data_cnt(): number of data bytes a channel status expects
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHAN_AT  = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   // Width of the baud counter; 13 bits covers BAUD_CNT up to 8192.
   localparam int unsigned CntW = 13;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

   // Data bytes expected after a channel status; 0 for anything else.
   function automatic logic [1:0] exp_data_cnt(input logic [7:0] status);
      logic [1:0] cnt;
      case (status[7:4])
         NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: cnt = 2'd2;
         PROG, CHAN_AT:                         cnt = 2'd1;
         default:                               cnt = 2'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// midi_rx_parser_if: serial MIDI input plus decoded-message outputs.
//   midi_rx    serial line, idle high (driven by slave side)
//   msg_valid  one-cycle strobe, complete channel message
//   msg_status status byte of the message
//   msg_data1  first data byte
//   msg_data2  second data byte, 0 for one-data-byte messages
//   frame_err  one-cycle strobe, stop bit sampled low
// master: the parser. slave: whoever feeds the line and consumes messages.
interface midi_rx_parser_if;
   logic       midi_rx;
   logic       msg_valid;
   logic [7:0] msg_status;
   logic [7:0] msg_data1;
   logic [7:0] msg_data2;
   logic       frame_err;

   modport master (
      input  midi_rx,
      output msg_valid, msg_status, msg_data1, msg_data2, frame_err
   );

   modport slave (
      output midi_rx,
      input  msg_valid, msg_status, msg_data1, msg_data2, frame_err
   );
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial byte receiver for the MIDI line.
//   clk          system clock
//   rst          asynchronous active-low reset
//   rx_i         raw serial line, idle high
//   byte_o       last received byte
//   byte_valid_o one-cycle strobe, the cycle after a good stop bit
//   frame_err_o  one-cycle strobe, the cycle after a low stop bit
// Parameter BAUD_CNT: clk cycles per bit.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned BAUD_CNT = 3200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_CNT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_CNT / 2 - 1);

   logic [1:0]      sync_q;
   logic            rx_prev_q;
   rx_state_e       state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            rx_s;

   assign rx_s = sync_q[1];

   // Synchronizer resets to the idle level so reset release is not a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx_i};
         rx_prev_q <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Counter restarts on every start edge, so timing never drifts.
               if (rx_prev_q && !rx_s) begin
                  state_q <= StStart;
                  cnt_q   <= '0;
               end
            end
            StStart: begin
               if (cnt_q == HalfLast) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_s ? StIdle : StData;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == BitLast) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= StStop;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (cnt_q == BitLast) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  if (rx_s) begin
                     byte_o       <= shift_q;
                     byte_valid_o <= 1'b1;
                  end else begin
                     frame_err_o <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: MIDI channel-message parser on top of midi_uart_rx.
//   clk      system clock
//   rst      asynchronous active-low reset
//   midi_io  midi_rx_parser_if.master: serial in, msg_* / frame_err out
// Parameter BAUD_CNT: clk cycles per MIDI bit (3200 = 31250 baud at 100 MHz).
// Build option MIDI_RUNNING_STATUS_EN: keep the status after a completed
// message so further data bytes form new messages (running status).
// Without it the status is invalidated after every message.
module midi_rx_parser
   import midi_pkg::*;
#(
   parameter int unsigned BAUD_CNT = 3200
) (
   input  logic            clk,
   input  logic            rst,
   midi_rx_parser_if.master midi_io
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ferr;

   midi_uart_rx #(
      .BAUD_CNT(BAUD_CNT)
   ) u_uart (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (midi_io.midi_rx),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .frame_err_o (rx_ferr)
   );

   logic [7:0] status_q;
   logic       status_vld_q;
   logic       idx_q;       // 0: expecting data1, 1: expecting data2
   logic [7:0] data1_q;
   logic       msg_valid_q;
   logic [7:0] msg_status_q;
   logic [7:0] msg_data1_q;
   logic [7:0] msg_data2_q;
   logic [1:0] need;

   assign need = exp_data_cnt(status_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q     <= '0;
         status_vld_q <= 1'b0;
         idx_q        <= 1'b0;
         data1_q      <= '0;
         msg_valid_q  <= 1'b0;
         msg_status_q <= '0;
         msg_data1_q  <= '0;
         msg_data2_q  <= '0;
      end else begin
         msg_valid_q <= 1'b0;
         if (rx_valid) begin
            if (rx_byte[7:3] == 5'b11111) begin
               // Real-time bytes pass through without touching any state.
            end else if (rx_byte[7:4] == 4'hF) begin
               status_vld_q <= 1'b0;
               idx_q        <= 1'b0;
            end else if (rx_byte[7]) begin
               // New status abandons any partial message.
               status_q     <= rx_byte;
               status_vld_q <= 1'b1;
               idx_q        <= 1'b0;
            end else if (status_vld_q) begin
               if (!idx_q && need == 2'd2) begin
                  data1_q <= rx_byte;
                  idx_q   <= 1'b1;
               end else begin
                  msg_valid_q  <= 1'b1;
                  msg_status_q <= status_q;
                  msg_data1_q  <= idx_q ? data1_q : rx_byte;
                  msg_data2_q  <= idx_q ? rx_byte : 8'h00;
                  idx_q        <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
                  status_vld_q <= 1'b1;
`else
                  status_vld_q <= 1'b0;
`endif
               end
            end
         end
      end
   end

   assign midi_io.msg_valid  = msg_valid_q;
   assign midi_io.msg_status = msg_status_q;
   assign midi_io.msg_data1  = msg_data1_q;
   assign midi_io.msg_data2  = msg_data2_q;
   assign midi_io.frame_err  = rx_ferr;

endmodule

// File: doc/midi_rx_parser.md
MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 3200, clk cycles per MIDI bit (31250 baud at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; reset rst, asynchronous, active-low; clock clk.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port midi_rx  input  1  asynchronous serial MIDI line, idle high.
REQ-005 SHALL have port msg_valid  output  1  one-cycle strobe, complete channel message.
REQ-006 SHALL have port msg_status  output  8  status byte of completed message.
REQ-007 SHALL have port msg_data1  output  8  first data byte.
REQ-008 SHALL have port msg_data2  output  8  second data byte, 0 for one-data-byte messages.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe, stop bit sampled low.

Function
REQ-010 SHALL pass midi_rx through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-011 SHALL run the byte receiver FSM with states IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
- START -> DATA if the line is still low at BAUD_CNT/2; otherwise -> IDLE.
- DATA samples 8 bits, LSB first, every BAUD_CNT cycles at bit centre.
- STOP samples once at bit centre, then -> IDLE.
REQ-012 SHALL pulse an internal byte_valid for 1 clk in the cycle after a stop bit sampled high.
REQ-013 SHALL pulse frame_err for 1 clk in the cycle after a stop bit sampled low, discard the byte, and leave parser state unchanged.
REQ-014 SHALL use a 13-bit baud counter that restarts on each start-bit detection, so there is no drift accumulation across bytes.
REQ-015 SHALL load status 0x80-0xEF into the status register and clear the data index.
- Expected data count: 2 for 0x8n, 0x9n, 0xAn, 0xBn, 0xEn; 1 for 0xCn, 0xDn.
REQ-016 SHALL ignore real-time bytes 0xF8-0xFF completely; no state change, even mid-message.
REQ-017 SHALL treat system common bytes 0xF0-0xF7 as clearing the status register to invalid; subsequent data bytes are dropped until a new channel status arrives.
REQ-018 SHALL drop a data byte (bit7=0) when the status is invalid.
REQ-019 SHALL store data bytes in data1 then data2 while the status is valid.
REQ-020 SHALL assert msg_valid in the cycle after byte_valid of the final expected data byte, update msg_* outputs in that same cycle, and hold msg_* until the next message.
REQ-021 SHALL, on a new status byte arriving mid-message, abandon the partial message without emitting it.

Reset
REQ-022 SHALL, with rst low, force msg_valid=0, frame_err=0, msg_status=0, msg_data1=0, msg_data2=0, receiver FSM to IDLE, status invalid, counters 0.
REQ-023 SHALL, on rst asserted mid-byte, discard the byte; after release the receiver waits for a fresh falling edge.

Configuration
REQ-024 SHALL, with MIDI_RUNNING_STATUS_EN defined, keep the status after a completed message; further data bytes then form new messages with the same status.
REQ-025 SHALL, without MIDI_RUNNING_STATUS_EN, invalidate the status after each completed message; data bytes without a preceding status are dropped.

Structure
REQ-026 SHALL take from shared package midi_pkg:
- status-nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CHAN_AT=D, PITCH=E);
- the receiver state enum;
- a function returning expected data count per status.
REQ-027 SHALL place the synchronizer, baud counter and byte FSM in sub-module midi_uart_rx (outputs byte, byte_valid, frame_err); midi_rx_parser contains the parser only.

Verification
REQ-028 SHALL verify: bytes B0 2E 7F at BAUD_CNT=3200 -> one msg_valid with status=B0, data1=2E, data2=7F, 1 clk after the final byte_valid.
REQ-029 SHALL verify: B0 2E 7F 2F 00 -> with MIDI_RUNNING_STATUS_EN, second msg B0/2F/00; without it, exactly one msg.
REQ-030 SHALL verify: C3 05 -> msg_valid with status=C3, data1=05, data2=00.
REQ-031 SHALL verify: B0 2E F8 7F -> single msg B0/2E/7F; F8 produces no output.
REQ-032 SHALL verify: byte 0x90 with stop bit forced 0, then 3C 40 -> frame_err pulse, no msg_valid (status never loaded).
REQ-033 SHALL verify: rst pulsed low during data bit 4 of 0x2E following B0 -> all outputs 0; a subsequent B0 2E 7F decodes correctly.
